dm_responder: RTL and testbench
===============================

DM_RESPONDER -- requirements
Module: dm_responder

Interface
REQ-001 Parameter ADDR_W, default 12, word-address width; the array holds 2**ADDR_W 32-bit words.
REQ-002 Parameter WAIT_CYCLES, default 2, number of wait states between accept and response (legal 0..15).
REQ-003 clk  input  1  single clock; all state changes on its rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 req_valid  input  1  initiator presents a request.
REQ-006 req_ready  output  1  responder can accept a request.
REQ-007 req_we  input  1  1 = store, 0 = load.
REQ-008 req_addr  input  32  byte address; bits [ADDR_W+1:2] select the word.
REQ-009 req_wdata  input  32  store data.
REQ-010 req_be  input  4  byte enables for stores, bit i covers wdata[8i+7:8i].
REQ-011 rsp_valid  output  1  response present.
REQ-012 rsp_ready  input  1  initiator consumes the response.
REQ-013 rsp_rdata  output  32  load data; 0 for stores and errors.
REQ-014 rsp_err  output  1  request was misaligned.

Function
REQ-015 The FSM SHALL have states IDLE, WAIT and RESP; req_ready SHALL be 1 only in IDLE.
REQ-016 Accept happens on a rising edge with req_valid && req_ready; we, addr, wdata and be are latched.
REQ-017 On accept, the FSM goes to WAIT with a counter loaded to WAIT_CYCLES-1, or straight to RESP when WAIT_CYCLES = 0.
REQ-018 In WAIT the counter decrements each cycle; at 0 the FSM goes to RESP.
REQ-019 rsp_valid is asserted exactly WAIT_CYCLES+1 cycles after the accept edge.
REQ-020 On entry to RESP, a store commits to the array and a load samples the array into rsp_rdata.
REQ-021 A load issued after a store to the same word returns the stored value.
REQ-022 rsp_valid, rsp_rdata and rsp_err SHALL hold stable while rsp_valid && !rsp_ready.
REQ-023 RESP goes to IDLE on rsp_ready; rsp_valid drops on that edge.
REQ-024 A new request cannot be accepted on the same edge (one outstanding request; throughput = 1 request per WAIT_CYCLES+2 cycles).
REQ-025 Misalignment (req_addr[1:0] != 0) SHALL produce rsp_err = 1 and rsp_rdata = 0, with no array write; latency is unchanged.
REQ-026 Address bits above ADDR_W+1 are ignored (aliasing wrap-around).
REQ-027 req_valid deasserted in WAIT/RESP has no effect; request inputs are not resampled after accept.

Reset
REQ-028 While reset is 0: state = IDLE, counter = 0, req_ready = 0, rsp_valid = 0, rsp_rdata = 0, rsp_err = 0, and all array words are cleared to 0.
REQ-029 Reset asserted mid-operation SHALL abort the request; an uncommitted store is discarded and no response is issued.
REQ-030 req_ready = 1 from the first rising edge after reset deasserts.

Configuration
REQ-031 Macro DM_RESPONDER_BYTE_EN: when defined, a store writes only the bytes enabled in req_be, and be = 4'b0000 is a legal no-op store that still responds.
REQ-032 Without DM_RESPONDER_BYTE_EN, req_be is ignored and every aligned store writes the full word.

Structure
REQ-033 Package dm_resp_pkg holds the state enum typedef (IDLE/WAIT/RESP), the default ADDR_W and WAIT_CYCLES, and a byte-merge function (old, new, be).
REQ-034 Sub-module dm_resp_array SHALL implement the array: async clear, single write port with byte merge, combinational read. FSM and handshake live in dm_responder.

Verification
REQ-035 Store then load: store 0xDEADBEEF to 0x0000_0010 with be = 4'hF, then load 0x10 -> rdata = 0xDEADBEEF and err = 0; each rsp_valid occurs 3 cycles after accept (WAIT_CYCLES = 2).
REQ-036 Backpressure: load with rsp_ready held 0 for 5 cycles -> rsp_valid/rdata stable and req_ready = 0 throughout; on rsp_ready = 1, back to IDLE next cycle.
REQ-037 Misaligned: store 0x12345678 to 0x0000_0022 -> err = 1; a later load of 0x20 returns 0x00000000.
REQ-038 Byte enable (macro defined): store 0x11223344 to 0x40, then store 0xAABBCCDD with be = 4'b0101 -> load 0x40 returns 0x11BB33DD; with the macro undefined it returns 0xAABBCCDD.
REQ-039 Reset mid-WAIT on a store of 0xCAFEF00D to 0x80 -> no response; after release, load 0x80 returns 0; load 0x4080 (ADDR_W = 12) aliases to 0x80.
REQ-040 WAIT_CYCLES = 0: back-to-back loads with rsp_ready tied to 1 -> rsp_valid 1 cycle after each accept, and one accept every 2 cycles.

Source files
------------

// File: rtl/dm_resp_pkg.sv
// Shared types, defaults and byte-merge helper for the dm_responder memory responder.
package dm_resp_pkg;

  localparam int DEF_ADDR_W      = 12;
  localparam int DEF_WAIT_CYCLES = 2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  function automatic logic [31:0] byte_merge(input logic [31:0] old_word,
                                             input logic [31:0] new_word,
                                             input logic [3:0]  be);
    logic [31:0] merged;
    for (int i = 0; i < 4; i++) begin
      merged[8*i +: 8] = be[i] ? new_word[8*i +: 8] : old_word[8*i +: 8];
    end
    return merged;
  endfunction

endpackage

// File: rtl/dm_responder_if.sv
// Request/response handshake bundle between an initiator (master) and dm_responder (slave).
interface dm_responder_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [3:0]  req_be;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  modport master (
    output req_valid, req_we, req_addr, req_wdata, req_be, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, req_be, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );
endinterface

// File: rtl/dm_resp_array.sv
// Word array for dm_responder: async clear, one byte-merging write port, combinational read.
module dm_resp_array
  import dm_resp_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       wdata,
  input  logic [3:0]        be,
  output logic [31:0]       rdata
);

  logic [31:0] mem [2**ADDR_W];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < 2**ADDR_W; i++) begin
        mem[i] <= '0;
      end
    end else if (we) begin
      mem[addr] <= byte_merge(mem[addr], wdata, be);
    end
  end

  assign rdata = mem[addr];

endmodule

// File: rtl/dm_responder.sv
// Single-outstanding memory responder with WAIT_CYCLES wait states before each response.
// Optional macro DM_RESPONDER_BYTE_EN enables per-byte store masking via req_be.
module dm_responder
  import dm_resp_pkg::*;
#(
  parameter int ADDR_W      = DEF_ADDR_W,
  parameter int WAIT_CYCLES = DEF_WAIT_CYCLES
) (
  input  logic           clk,
  input  logic           reset,
  dm_responder_if.slave  bus
);

  localparam logic [3:0] CNT_INIT = (WAIT_CYCLES == 0) ? 4'd0 : 4'(WAIT_CYCLES - 1);

  state_t            state, state_next;
  logic [3:0]        cnt;
  logic              armed;
  logic              accept;
  logic              enter_resp;
  logic              lat_we, lat_mis;
  logic [ADDR_W-1:0] lat_word;
  logic [31:0]       lat_wdata;
  logic              cur_we, cur_mis;
  logic [ADDR_W-1:0] cur_word;
  logic [31:0]       cur_wdata;
  logic [3:0]        cur_be;
  logic              arr_we;
  logic [31:0]       arr_rdata;
  logic [31:0]       rsp_rdata_q;
  logic              rsp_err_q;
  logic              unused_bits;

  // armed keeps req_ready low until the first edge after reset release
  assign bus.req_ready = armed && (state == IDLE);
  assign accept        = bus.req_valid && bus.req_ready;

  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:    if (accept) state_next = (WAIT_CYCLES == 0) ? RESP : WAIT;
      WAIT:    if (cnt == 4'd0) state_next = RESP;
      RESP:    if (bus.rsp_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  assign enter_resp = (state != RESP) && (state_next == RESP);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      cnt   <= 4'd0;
      armed <= 1'b0;
    end else begin
      state <= state_next;
      armed <= 1'b1;
      if (accept) begin
        cnt <= CNT_INIT;
      end else if (state == WAIT && cnt != 4'd0) begin
        cnt <= cnt - 4'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      lat_we    <= bus.req_we;
      lat_mis   <= (bus.req_addr[1:0] != 2'b00);
      lat_word  <= bus.req_addr[ADDR_W+1:2];
      lat_wdata <= bus.req_wdata;
    end
  end

  // With zero wait states RESP is entered on the accept edge itself, so use live inputs there
  assign cur_we    = (state == IDLE) ? bus.req_we                      : lat_we;
  assign cur_mis   = (state == IDLE) ? (bus.req_addr[1:0] != 2'b00)    : lat_mis;
  assign cur_word  = (state == IDLE) ? bus.req_addr[ADDR_W+1:2]        : lat_word;
  assign cur_wdata = (state == IDLE) ? bus.req_wdata                   : lat_wdata;

`ifdef DM_RESPONDER_BYTE_EN
  logic [3:0] lat_be;

  always_ff @(posedge clk) begin
    if (accept) lat_be <= bus.req_be;
  end

  assign cur_be      = (state == IDLE) ? bus.req_be : lat_be;
  assign unused_bits = ^bus.req_addr[31:ADDR_W+2];
`else
  assign cur_be      = 4'hF;
  assign unused_bits = ^{bus.req_addr[31:ADDR_W+2], bus.req_be};
`endif

  assign arr_we = enter_resp && cur_we && !cur_mis;

  dm_resp_array #(.ADDR_W(ADDR_W)) u_array (
    .clk   (clk),
    .reset (reset),
    .we    (arr_we),
    .addr  (cur_word),
    .wdata (cur_wdata),
    .be    (cur_be),
    .rdata (arr_rdata)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
    end else if (enter_resp) begin
      rsp_rdata_q <= (cur_we || cur_mis) ? 32'h0 : arr_rdata;
      rsp_err_q   <= cur_mis;
    end
  end

  assign bus.rsp_valid = (state == RESP);
  assign bus.rsp_rdata = rsp_rdata_q;
  assign bus.rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_dm_responder.sv
// Scoreboard bench for dm_responder: WAIT_CYCLES=2 instance with random backpressure, plus a WAIT_CYCLES=0 instance.
module tb_dm_responder;

  logic clk    = 1'b0;
  logic reset  = 1'b1;
  logic reset0 = 1'b1;
  int   cyc    = 0;
  int   nchecks = 0;
  int   nerrors = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  dm_responder_if bus ();
  dm_responder_if bus0 ();

  dm_responder #(.ADDR_W(12), .WAIT_CYCLES(2)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  dm_responder #(.ADDR_W(12), .WAIT_CYCLES(0)) dut0 (
    .clk   (clk),
    .reset (reset0),
    .bus   (bus0)
  );

  typedef struct {
    logic [31:0] rd;
    logic        err;
    int          acc;
  } exp_t;

  exp_t        q[$];
  exp_t        q0[$];
  logic [31:0] mdl [int];
  logic [31:0] mdl0 [int];

  bit          mon_en = 0;
  bit          mon0_en = 0;
  bit          done0 = 0;
  bit          holding = 0;
  bit          expect_idle = 0;
  int          hold_left = 0;
  int          force_hold = 0;
  logic [31:0] held_rd;
  logic        held_err;
  exp_t        e_main;
  exp_t        e_w0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    nchecks++;
    if (act !== req) begin
      nerrors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic fail_now(input string name);
    nchecks++;
    nerrors++;
    $display("FAIL %s (cycle %0d)", name, cyc);
  endtask

  // Reference memory: word index is byte address / 4 modulo 4096 words
  function automatic exp_t model(input bit sel, input logic we, input logic [31:0] addr,
                                 input logic [31:0] wdata, input logic [3:0] be, input int acc);
    exp_t        e;
    int          w;
    logic [31:0] cur;
    logic [3:0]  eff_be;
    w = int'((addr / 4) % 4096);
    if (sel) cur = mdl0.exists(w) ? mdl0[w] : 32'h0;
    else     cur = mdl.exists(w)  ? mdl[w]  : 32'h0;
`ifdef DM_RESPONDER_BYTE_EN
    eff_be = be;
`else
    eff_be = be | 4'hF;
`endif
    e.acc = acc;
    e.err = 1'b0;
    e.rd  = 32'h0;
    if (addr % 4 != 0) begin
      e.err = 1'b1;
    end else if (we) begin
      for (int b = 0; b < 4; b++) if (eff_be[b]) cur[8*b +: 8] = wdata[8*b +: 8];
      if (sel) mdl0[w] = cur;
      else     mdl[w]  = cur;
    end else begin
      e.rd = cur;
    end
    return e;
  endfunction

  task automatic do_req(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [3:0] be);
    int t = 0;
    while (!bus.req_ready && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (!bus.req_ready) begin
      fail_now("req_ready_timeout");
      return;
    end
    bus.req_valid = 1'b1;
    bus.req_we    = we;
    bus.req_addr  = addr;
    bus.req_wdata = wdata;
    bus.req_be    = be;
    q.push_back(model(1'b0, we, addr, wdata, be, cyc + 1));
    @(negedge clk);
    bus.req_valid = 1'b0;
    bus.req_we    = 1'($urandom);
    bus.req_addr  = $urandom;
    bus.req_wdata = $urandom;
    bus.req_be    = 4'($urandom);
  endtask

  task automatic drain();
    int t = 0;
    while ((q.size() != 0 || holding) && t < 300) begin
      @(negedge clk);
      t++;
    end
    if (t >= 300) fail_now("drain_timeout");
  endtask

  task automatic apply_reset();
    reset = 1'b0;
    @(posedge clk);
    q.delete();
    mdl.delete();
    @(negedge clk);
    chk("rst_req_ready", 32'(bus.req_ready), 32'd0);
    chk("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    chk("rst_rsp_rdata", bus.rsp_rdata, 32'h0);
    chk("rst_rsp_err",   32'(bus.rsp_err), 32'd0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("post_rst_req_ready", 32'(bus.req_ready), 32'd1);
  endtask

  initial begin : mon
    bus.rsp_ready = 1'b0;
    forever begin
      @(negedge clk);
      if (!reset) begin
        holding     = 0;
        expect_idle = 0;
        hold_left   = 0;
      end else if (mon_en) begin
        if (expect_idle) begin
          chk("idle_req_ready", 32'(bus.req_ready), 32'd1);
          chk("idle_rsp_valid", 32'(bus.rsp_valid), 32'd0);
          expect_idle = 0;
        end
        if (holding) begin
          chk("hold_rsp_valid", 32'(bus.rsp_valid), 32'd1);
          chk("hold_rdata",     bus.rsp_rdata, held_rd);
          chk("hold_err",       32'(bus.rsp_err), 32'(held_err));
          chk("hold_req_ready", 32'(bus.req_ready), 32'd0);
        end else if (bus.rsp_valid) begin
          if (q.size() == 0) begin
            fail_now("unexpected_rsp");
            held_rd  = bus.rsp_rdata;
            held_err = bus.rsp_err;
          end else begin
            e_main = q.pop_front();
            chk("rsp_rdata",     bus.rsp_rdata, e_main.rd);
            chk("rsp_err",       32'(bus.rsp_err), 32'(e_main.err));
            chk("rsp_latency",   32'(cyc + 1 - e_main.acc), 32'd3);
            chk("rsp_req_ready", 32'(bus.req_ready), 32'd0);
            held_rd   = e_main.rd;
            held_err  = e_main.err;
            hold_left = force_hold;
            force_hold = 0;
          end
        end
        if (bus.rsp_valid) begin
          if (hold_left > 0) begin
            bus.rsp_ready = 1'b0;
            hold_left--;
          end else begin
            bus.rsp_ready = ($urandom_range(0, 3) != 0);
          end
          holding     = !bus.rsp_ready;
          expect_idle = bus.rsp_ready;
        end else begin
          holding       = 0;
          bus.rsp_ready = 1'($urandom_range(0, 1));
        end
      end
    end
  end

  initial begin : mon0
    forever begin
      @(negedge clk);
      if (mon0_en && reset0 && bus0.rsp_valid) begin
        if (q0.size() == 0) begin
          fail_now("w0_unexpected_rsp");
        end else begin
          e_w0 = q0.pop_front();
          chk("w0_rdata",   bus0.rsp_rdata, e_w0.rd);
          chk("w0_err",     32'(bus0.rsp_err), 32'(e_w0.err));
          chk("w0_latency", 32'(cyc + 1 - e_w0.acc), 32'd1);
        end
      end
    end
  end

  initial begin : drv0
    int prev_acc = 0;
    int acc;
    int t;
    logic [31:0] a;
    bus0.req_valid = 1'b0;
    bus0.req_we    = 1'b0;
    bus0.req_addr  = 32'h0;
    bus0.req_wdata = 32'h0;
    bus0.req_be    = 4'h0;
    bus0.rsp_ready = 1'b1;
    @(negedge clk);
    reset0 = 1'b0;
    repeat (2) @(negedge clk);
    reset0 = 1'b1;
    mon0_en = 1;
    @(negedge clk);
    for (int i = 0; i < 40; i++) begin
      a = 32'($urandom_range(0, 7)) * 4;
      if ($urandom_range(0, 7) == 0) a = a + 32'($urandom_range(1, 3));
      bus0.req_valid = 1'b1;
      bus0.req_we    = 1'($urandom);
      bus0.req_addr  = a;
      bus0.req_wdata = $urandom;
      bus0.req_be    = 4'($urandom);
      t = 0;
      while (!bus0.req_ready && t < 20) begin
        @(negedge clk);
        t++;
      end
      if (!bus0.req_ready) begin
        fail_now("w0_req_ready_timeout");
        break;
      end
      acc = cyc + 1;
      if (i > 0) chk("w0_accept_spacing", 32'(acc - prev_acc), 32'd2);
      prev_acc = acc;
      q0.push_back(model(1'b1, bus0.req_we, bus0.req_addr, bus0.req_wdata, bus0.req_be, acc));
      @(negedge clk);
    end
    bus0.req_valid = 1'b0;
    done0 = 1;
  end

  initial begin : main
    logic [31:0] addr;
    int t;
    bus.req_valid = 1'b0;
    bus.req_we    = 1'b0;
    bus.req_addr  = 32'h0;
    bus.req_wdata = 32'h0;
    bus.req_be    = 4'h0;
    @(negedge clk);
    apply_reset();
    mon_en = 1;

    do_req(1'b1, 32'h0000_0010, 32'hDEADBEEF, 4'hF);
    drain();
    do_req(1'b0, 32'h0000_0010, 32'h0, 4'h0);
    drain();

    force_hold = 5;
    do_req(1'b0, 32'h0000_0010, 32'h0, 4'h0);
    drain();

    do_req(1'b1, 32'h0000_0022, 32'h12345678, 4'hF);
    do_req(1'b0, 32'h0000_0020, 32'h0, 4'h0);
    drain();

    do_req(1'b1, 32'h0000_0040, 32'h11223344, 4'hF);
    do_req(1'b1, 32'h0000_0040, 32'hAABBCCDD, 4'b0101);
    do_req(1'b0, 32'h0000_0040, 32'h0, 4'h0);
    drain();

    // Reset lands while the store is still waiting
    do_req(1'b1, 32'h0000_0080, 32'hCAFEF00D, 4'hF);
    apply_reset();
    do_req(1'b0, 32'h0000_0080, 32'h0, 4'h0);
    do_req(1'b1, 32'h0000_0080, 32'h5A5A1234, 4'hF);
    do_req(1'b0, 32'h0000_4080, 32'h0, 4'h0);
    drain();

    for (int i = 0; i < 150; i++) begin
      addr = ($urandom & 32'hFFFF_C000) | (32'($urandom_range(0, 15)) * 4);
      if ($urandom_range(0, 7) == 0) addr = addr | 32'($urandom_range(1, 3));
      do_req(1'($urandom), addr, $urandom, 4'($urandom));
    end
    drain();

    t = 0;
    while ((!done0 || q0.size() != 0) && t < 500) begin
      @(negedge clk);
      t++;
    end
    if (t >= 500) fail_now("w0_finish_timeout");
    repeat (3) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", nchecks, nerrors);
    $finish;
  end

endmodule
